// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse display path: character codes and
// the scan FSM state encoding.
package morse_pkg;

  typedef logic [5:0] char_t;

  // The decoder's default case renders this code dark.
  localparam char_t BLANK_CODE = 6'h3F;

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } scan_state_t;

endpackage

// File: rtl/char_shift_buf.sv
// Scrolling character buffer: newest character enters slot 0 (rightmost digit),
// older ones move left, and the oldest falls out. Tracks how many slots are filled.
module char_shift_buf
  import morse_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  localparam int IDX_W      = $clog2(NUM_DIGITS),
  localparam int FILL_W     = IDX_W + 1
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              wr_en,
  input  char_t             wr_data,
  input  logic              clear,
  input  logic [IDX_W-1:0]  rd_idx,
  output char_t             rd_data,
  output logic [FILL_W-1:0] fill
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_DIGITS);

  char_t slots [NUM_DIGITS];

  // NOTE: sequential state uses non-blocking assignments so every slot samples
  // its neighbour's pre-edge value; blocking here would smear one character
  // across the whole buffer in a single clock.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      // NOTE: this storage is reset on purpose: a blank display after reset is
      // visible behaviour, unlike a RAM whose contents are don't-care.
      for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= BLANK_CODE;
      fill <= '0;
    end else if (clear) begin
      // A character arriving with clear is dropped.
      for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= BLANK_CODE;
      fill <= '0;
    end else if (wr_en) begin
      slots[0] <= wr_data;
      for (int i = 1; i < NUM_DIGITS; i++) slots[i] <= slots[i-1];
      if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
    end
  end

  assign rd_data = slots[rd_idx];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Display scheduler: buffers received characters and time-multiplexes the shared
// seven-segment decoder across the digit anodes with a blanking gap between digits.
module seg_scan_ctrl
  import morse_pkg::*;
#(
  parameter  int NUM_DIGITS   = 8,
  parameter  int DIGIT_CYCLES = 100000,
  parameter  int BLANK_CYCLES = 1000,
  localparam int IDX_W        = $clog2(NUM_DIGITS),
  localparam int FILL_W       = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  data_valid,
  input  logic [5:0]            char_data,
  input  logic                  clear,
  output logic [5:0]            char_code,
  output logic [NUM_DIGITS-1:0] an,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  new_seg,
  output logic [FILL_W-1:0]     fill
);

  localparam int TIMER_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX);

  localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DRIVE_LAST = TIMER_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t            state, state_d;
  logic [TIMER_W-1:0]     timer, timer_d;
  logic [IDX_W-1:0]       idx_d;
  logic [NUM_DIGITS-1:0]  an_d;
  logic                   new_seg_d;
  char_t                  rd_data;

  char_shift_buf #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_buf (
    .clk     (clk),
    .res_n   (res_n),
    .wr_en   (data_valid),
    .wr_data (char_data),
    .clear   (clear),
    .rd_idx  (digit_idx),
    .rd_data (rd_data),
    .fill    (fill)
  );

  // State register; an/new_seg/char_code are registered so no input reaches an
  // output combinationally.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= S_BLANK;
      timer     <= '0;
      digit_idx <= '0;
      an        <= '1;
      new_seg   <= 1'b0;
      char_code <= BLANK_CODE;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      digit_idx <= idx_d;
      an        <= an_d;
      new_seg   <= new_seg_d;
      char_code <= rd_data;
    end
  end

  // Next-state: digit_idx advances on leaving S_DRIVE, so during S_BLANK it
  // already names the digit about to be driven.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    state_d = state;
    timer_d = timer + TIMER_W'(1);
    idx_d   = digit_idx;
    case (state)
      S_BLANK: begin
        if (timer == BLANK_LAST) begin
          state_d = S_DRIVE;
          timer_d = '0;
        end
      end
      S_DRIVE: begin
        if (timer == DRIVE_LAST) begin
          state_d = S_BLANK;
          timer_d = '0;
          idx_d   = (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_BLANK;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered anodes line up
  // with the state register cycle for cycle.
  always_comb begin
    an_d      = '1;
    new_seg_d = 1'b0;
    if (state_d == S_DRIVE) begin
      an_d[idx_d] = 1'b0;
      new_seg_d   = (state == S_BLANK);
    end
  end

endmodule
